// File: rtl/tcm_dec_types.sv
// Shared types and helpers for the TCM decoder traceback path.
//   cSTATE_NUM / cSTATE_W : default trellis size and state index width
//   cMETRIC_W             : default path metric width
//   stateb_t              : state index
//   trel_statem_t         : path metric (modulo arithmetic)
//   statem_better()       : strict "a is better than b" under wrap-around metric arithmetic
package tcm_dec_types;

  localparam int unsigned cSTATE_NUM = 64;
  localparam int unsigned cSTATE_W   = $clog2(cSTATE_NUM);
  localparam int unsigned cMETRIC_W  = 8;

  typedef logic [cSTATE_W-1:0]  stateb_t;
  typedef logic [cMETRIC_W-1:0] trel_statem_t;

  // a and b are zero-extended metrics of width w (w < 32). The difference is taken modulo 2^w
  // and read as signed, so metrics that have wrapped still compare correctly while their
  // spread stays below 2^(w-1). Equal metrics are never "better".
  function automatic logic statem_better(input logic [31:0]   a,
                                         input logic [31:0]   b,
                                         input int unsigned   w,
                                         input logic          min_mode);
    logic [31:0] diff;
    logic        neg;
    logic        zero;
    diff = (a - b) & ((32'h1 << w) - 32'h1);
    neg  = diff[5'(w - 1)];
    zero = (diff == 32'h0);
    return min_mode ? neg : (!neg && !zero);
  endfunction

endpackage

// File: rtl/tcm_dec_trb_cmp_node.sv
// Combinational 2:1 compare-select node of the best-state tree.
//   ia_* : lower-index operand {metric, index, tie}
//   ib_* : higher-index operand {metric, index, tie}
//   o*   : selected {metric, index, tie}
// Equal metrics select the lower-index operand and raise the tie flag; otherwise the tie flag
// of the selected operand is passed on.
module tcm_dec_trb_cmp_node
  import tcm_dec_types::*;
#(
  parameter int unsigned pMETRIC_W = 8,
  parameter int unsigned pIDX_W    = 6,
  parameter int unsigned pMIN_MODE = 0
) (
  input  logic [pMETRIC_W-1:0] ia_metric,
  input  logic [pIDX_W-1:0]    ia_idx,
  input  logic                 ia_tie,
  input  logic [pMETRIC_W-1:0] ib_metric,
  input  logic [pIDX_W-1:0]    ib_idx,
  input  logic                 ib_tie,
  output logic [pMETRIC_W-1:0] ometric,
  output logic [pIDX_W-1:0]    oidx,
  output logic                 otie
);

  logic eq;
  logic a_better;
  logic sel_b;

  always_comb begin
    eq       = (ia_metric == ib_metric);
    a_better = statem_better(32'(ia_metric), 32'(ib_metric), pMETRIC_W, pMIN_MODE != 0);
    sel_b    = !a_better && !eq;
    ometric  = sel_b ? ib_metric : ia_metric;
    oidx     = sel_b ? ib_idx    : ia_idx;
    otie     = eq | (sel_b ? ib_tie : ia_tie);
  end

endmodule

// File: rtl/tcm_dec_trb_decision_pipe.sv
// Best-state search for the Viterbi traceback: reduces pSTATE_NUM path metrics to the index and
// metric of the best state through a pipelined binary compare-select tree.
//   iclk, ireset, iclkena : clock, synchronous active-high reset, clock enable
//   ival, isop, ieop      : metric vector valid and frame markers
//   istatem               : metric array, index = state number
//   oval, osop, oeop      : delayed valid and frame markers (latency = ceil(D/pREG_EVERY))
//   ostate, ometric, otie : best state, its metric, tie seen on the winning path
module tcm_dec_trb_decision_pipe
  import tcm_dec_types::*;
#(
  parameter int unsigned pSTATE_NUM = cSTATE_NUM,
  parameter int unsigned pMETRIC_W  = cMETRIC_W,
  parameter int unsigned pREG_EVERY = 1,
  parameter int unsigned pMIN_MODE  = 0,
  localparam int unsigned cD   = $clog2(pSTATE_NUM),
  localparam int unsigned cLAT = (cD + pREG_EVERY - 1) / pREG_EVERY
) (
  input  logic                                 iclk,
  input  logic                                 ireset,
  input  logic                                 iclkena,
  input  logic                                 ival,
  input  logic                                 isop,
  input  logic                                 ieop,
  input  logic [pSTATE_NUM-1:0][pMETRIC_W-1:0] istatem,
  output logic                                 oval,
  output logic                                 osop,
  output logic                                 oeop,
  output logic [cD-1:0]                        ostate,
  output logic [pMETRIC_W-1:0]                 ometric,
  output logic                                 otie
);

  // Compare-select tree. Level k reduces 2*N candidates to N; index bits ride with the metric.
  for (genvar k = 0; k < cD; k++) begin : g_lvl
    localparam int unsigned N     = pSTATE_NUM >> (k + 1);
    localparam bit          IsReg = (((k + 1) % pREG_EVERY) == 0) || (k == cD - 1);

    logic [pMETRIC_W-1:0] in_metric  [2*N];
    logic [cD-1:0]        in_idx     [2*N];
    logic                 in_tie     [2*N];
    logic [pMETRIC_W-1:0] sel_metric [N];
    logic [cD-1:0]        sel_idx    [N];
    logic                 sel_tie    [N];
    logic [pMETRIC_W-1:0] out_metric [N];
    logic [cD-1:0]        out_idx    [N];
    logic                 out_tie    [N];

    for (genvar j = 0; j < 2 * N; j++) begin : g_in
      if (k == 0) begin : g_leaf
        assign in_metric[j] = istatem[j];
        assign in_idx[j]    = cD'(j);
        assign in_tie[j]    = 1'b0;
      end else begin : g_prev
        assign in_metric[j] = g_lvl[k-1].out_metric[j];
        assign in_idx[j]    = g_lvl[k-1].out_idx[j];
        assign in_tie[j]    = g_lvl[k-1].out_tie[j];
      end
    end

    for (genvar j = 0; j < N; j++) begin : g_node
      tcm_dec_trb_cmp_node #(
        .pMETRIC_W (pMETRIC_W),
        .pIDX_W    (cD),
        .pMIN_MODE (pMIN_MODE)
      ) u_node (
        .ia_metric (in_metric[2*j]),
        .ia_idx    (in_idx[2*j]),
        .ia_tie    (in_tie[2*j]),
        .ib_metric (in_metric[2*j+1]),
        .ib_idx    (in_idx[2*j+1]),
        .ib_tie    (in_tie[2*j+1]),
        .ometric   (sel_metric[j]),
        .oidx      (sel_idx[j]),
        .otie      (sel_tie[j])
      );
    end

    if (IsReg) begin : g_reg
      // Data registers carry no reset; validity is tracked by the control pipe.
      logic [pMETRIC_W-1:0] metric_q [N];
      logic [cD-1:0]        idx_q    [N];
      logic                 tie_q    [N];

      always_ff @(posedge iclk) begin
        if (iclkena) begin
          metric_q <= sel_metric;
          idx_q    <= sel_idx;
          tie_q    <= sel_tie;
        end
      end

      assign out_metric = metric_q;
      assign out_idx    = idx_q;
      assign out_tie    = tie_q;
    end else begin : g_comb
      assign out_metric = sel_metric;
      assign out_idx    = sel_idx;
      assign out_tie    = sel_tie;
    end
  end

  assign ostate  = g_lvl[cD-1].out_idx[0];
  assign ometric = g_lvl[cD-1].out_metric[0];
  assign otie    = g_lvl[cD-1].out_tie[0];

  // Control pipe, one stage per registered tree level. Markers are qualified by ival on entry.
  logic [cLAT-1:0] val_d, val_q;
  logic [cLAT-1:0] sop_d, sop_q;
  logic [cLAT-1:0] eop_d, eop_q;

  always_comb begin
    val_d    = val_q << 1;
    sop_d    = sop_q << 1;
    eop_d    = eop_q << 1;
    val_d[0] = ival;
    sop_d[0] = ival & isop;
    eop_d[0] = ival & ieop;
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      val_q <= '0;
      sop_q <= '0;
      eop_q <= '0;
    end else if (iclkena) begin
      val_q <= val_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
    end
  end

  assign oval = val_q[cLAT-1];
  assign osop = sop_q[cLAT-1];
  assign oeop = eop_q[cLAT-1];

endmodule

// File: tb/tb_tcm_dec_trb_decision_pipe.sv
// Bench for tcm_dec_trb_decision_pipe: three instances (max/R=1, max/R=2, min/R=3) share the
// same stimulus; a tick-indexed scoreboard fed by a level-by-level reference reduction checks
// every output cycle, plus directed table vectors and reset / clock-enable sequences.
module tb_tcm_dec_trb_decision_pipe;
  import tcm_dec_types::*;

  localparam int NDUT = 3;
  localparam int unsigned LAT  [NDUT] = '{6, 3, 2};
  localparam int unsigned MINM [NDUT] = '{0, 0, 1};

  typedef logic [63:0][7:0] vec_t;

  typedef struct packed {
    logic       vld;
    logic       sop;
    logic       eop;
    logic       tie;
    logic [5:0] st;
    logic [7:0] met;
  } exp_t;

  typedef struct {
    int unsigned min_mode;
    vec_t        m;
    int unsigned st;
    int unsigned met;
    int unsigned tie;
  } tab_t;

  typedef enum int {EdgeNone, EdgeRst, EdgeEn, EdgeHold} edge_kind_e;

  logic iclk = 1'b0;
  logic ireset, iclkena, ival, isop, ieop;
  vec_t istatem;

  logic [NDUT-1:0] oval_w, osop_w, oeop_w, otie_w;
  logic [5:0]      ostate_w  [NDUT];
  logic [7:0]      ometric_w [NDUT];

  always #5 iclk = ~iclk;

  tcm_dec_trb_decision_pipe #(.pSTATE_NUM(64), .pMETRIC_W(8), .pREG_EVERY(1), .pMIN_MODE(0)) u_dut0 (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop), .ieop(ieop),
    .istatem(istatem), .oval(oval_w[0]), .osop(osop_w[0]), .oeop(oeop_w[0]),
    .ostate(ostate_w[0]), .ometric(ometric_w[0]), .otie(otie_w[0]));

  tcm_dec_trb_decision_pipe #(.pSTATE_NUM(64), .pMETRIC_W(8), .pREG_EVERY(2), .pMIN_MODE(0)) u_dut1 (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop), .ieop(ieop),
    .istatem(istatem), .oval(oval_w[1]), .osop(osop_w[1]), .oeop(oeop_w[1]),
    .ostate(ostate_w[1]), .ometric(ometric_w[1]), .otie(otie_w[1]));

  tcm_dec_trb_decision_pipe #(.pSTATE_NUM(64), .pMETRIC_W(8), .pREG_EVERY(3), .pMIN_MODE(1)) u_dut2 (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop), .ieop(ieop),
    .istatem(istatem), .oval(oval_w[2]), .osop(osop_w[2]), .oeop(oeop_w[2]),
    .ostate(ostate_w[2]), .ometric(ometric_w[2]), .otie(otie_w[2]));

  int checks = 0;
  int errors = 0;

  // Reference: pairwise reduction straight from the node rules, with plain signed arithmetic.
  function automatic exp_t mk_exp(input vec_t m, input int unsigned min_mode,
                                  input logic sop, input logic eop);
    logic [7:0] cm [64];
    int         ci [64];
    bit         ct [64];
    int         n;
    exp_t       r;
    for (int s = 0; s < 64; s++) begin
      cm[s] = m[s];
      ci[s] = s;
      ct[s] = 1'b0;
    end
    n = 64;
    while (n > 1) begin
      for (int j = 0; j < n / 2; j++) begin
        logic [7:0] d;
        bit         take_a;
        d = cm[2*j] - cm[2*j+1];
        if (d == 8'd0) take_a = 1'b1;
        else           take_a = (min_mode != 0) ? ($signed(d) < 0) : ($signed(d) > 0);
        if (take_a) begin
          ct[j] = ct[2*j] | (d == 8'd0);
          cm[j] = cm[2*j];
          ci[j] = ci[2*j];
        end else begin
          ct[j] = ct[2*j+1];
          cm[j] = cm[2*j+1];
          ci[j] = ci[2*j+1];
        end
      end
      n = n / 2;
    end
    r.vld = 1'b1;
    r.sop = sop;
    r.eop = eop;
    r.tie = ct[0];
    r.st  = 6'(ci[0]);
    r.met = cm[0];
    return r;
  endfunction

  // Expected results indexed by the enabled-clock count at which they must appear.
  exp_t        exp_tab [NDUT][64];
  int unsigned tick = 0;
  edge_kind_e  last_edge = EdgeNone;

  always @(posedge iclk) begin
    if (ireset) begin
      for (int d = 0; d < NDUT; d++)
        for (int i = 0; i < 64; i++) exp_tab[d][i].vld <= 1'b0;
      last_edge <= EdgeRst;
    end else if (iclkena) begin
      tick      <= tick + 1;
      last_edge <= EdgeEn;
      for (int d = 0; d < NDUT; d++) begin
        exp_tab[d][tick % 64].vld <= 1'b0;
        if (ival) exp_tab[d][(tick + LAT[d]) % 64] <= mk_exp(istatem, MINM[d], isop, ieop);
      end
    end else begin
      last_edge <= EdgeHold;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  logic [NDUT-1:0] prev_val, prev_sop, prev_eop, prev_tie;
  logic [5:0]      prev_st  [NDUT];
  logic [7:0]      prev_met [NDUT];
  int              oval_cnt [NDUT] = '{0, 0, 0};
  int              got_q[$];

  task automatic sb_check();
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      if (last_edge == EdgeRst) begin
        check($sformatf("rst_oval_d%0d", d), 32'(oval_w[d]), 0);
        check($sformatf("rst_osop_d%0d", d), 32'(osop_w[d]), 0);
        check($sformatf("rst_oeop_d%0d", d), 32'(oeop_w[d]), 0);
      end else if (last_edge == EdgeHold) begin
        check($sformatf("hold_oval_d%0d", d), 32'(oval_w[d]), 32'(prev_val[d]));
        check($sformatf("hold_state_d%0d", d), 32'(ostate_w[d]), 32'(prev_st[d]));
        check($sformatf("hold_metric_d%0d", d), 32'(ometric_w[d]), 32'(prev_met[d]));
      end else if (last_edge == EdgeEn) begin
        e = exp_tab[d][tick % 64];
        check($sformatf("sb_oval_d%0d_t%0d", d, tick), 32'(oval_w[d]), 32'(e.vld));
        check($sformatf("sb_osop_d%0d_t%0d", d, tick), 32'(osop_w[d]), e.vld ? 32'(e.sop) : 0);
        check($sformatf("sb_oeop_d%0d_t%0d", d, tick), 32'(oeop_w[d]), e.vld ? 32'(e.eop) : 0);
        if (e.vld) begin
          check($sformatf("sb_state_d%0d_t%0d", d, tick), 32'(ostate_w[d]), 32'(e.st));
          check($sformatf("sb_metric_d%0d_t%0d", d, tick), 32'(ometric_w[d]), 32'(e.met));
          check($sformatf("sb_tie_d%0d_t%0d", d, tick), 32'(otie_w[d]), 32'(e.tie));
        end
        if (oval_w[d] === 1'b1) begin
          oval_cnt[d]++;
          if (d == 0) got_q.push_back(int'(ostate_w[0]) | (int'(ometric_w[0]) << 8)
                                      | (int'(otie_w[0]) << 16));
        end
      end
      prev_val[d] = oval_w[d];
      prev_sop[d] = osop_w[d];
      prev_eop[d] = oeop_w[d];
      prev_tie[d] = otie_w[d];
      prev_st[d]  = ostate_w[d];
      prev_met[d] = ometric_w[d];
    end
  endtask

  task automatic nxt();
    @(negedge iclk);
    sb_check();
  endtask

  function automatic vec_t rand_vec();
    vec_t       v;
    logic [7:0] base;
    bit         narrow;
    base   = 8'($urandom_range(0, 255));
    narrow = 1'($urandom_range(0, 1));
    for (int s = 0; s < 64; s++)
      v[s] = narrow ? 8'(base + 8'($urandom_range(0, 3))) : 8'($urandom_range(0, 255));
    return v;
  endfunction

  // Applies one vector, then watches each instance for its first oval; records latency/result.
  int          lat_got [NDUT];
  logic [5:0]  st_got  [NDUT];
  logic [7:0]  met_got [NDUT];
  logic        tie_got [NDUT];

  task automatic single(input vec_t m);
    bit seen [NDUT];
    for (int d = 0; d < NDUT; d++) begin
      seen[d]    = 1'b0;
      lat_got[d] = 0;
    end
    ival    = 1'b1;
    istatem = m;
    for (int n = 1; n <= 12; n++) begin
      nxt();
      ival = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
        if (!seen[d] && oval_w[d] === 1'b1) begin
          seen[d]    = 1'b1;
          lat_got[d] = n;
          st_got[d]  = ostate_w[d];
          met_got[d] = ometric_w[d];
          tie_got[d] = otie_w[d];
        end
      end
    end
  endtask

  vec_t stream [100];
  int   ref_seq[$];

  task automatic run_stream(input bit rand_en);
    int c0 [NDUT];
    for (int d = 0; d < NDUT; d++) c0[d] = oval_cnt[d];
    got_q.delete();
    for (int i = 0; i < 100; i++) begin
      ival    = 1'b1;
      isop    = (i == 0);
      ieop    = (i == 99);
      istatem = stream[i];
      iclkena = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      nxt();
      while (!iclkena) begin
        iclkena = 1'($urandom_range(0, 1));
        nxt();
      end
    end
    ival = 1'b0;
    isop = 1'b0;
    ieop = 1'b0;
    for (int n = 0; n < 20; n++) begin
      iclkena = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      nxt();
    end
    iclkena = 1'b1;
    repeat (8) nxt();
    for (int d = 0; d < NDUT; d++)
      check($sformatf("stream_count_d%0d_en%0d", d, rand_en), oval_cnt[d] - c0[d], 100);
  endtask

  tab_t tab [7];

  initial begin
    ireset  = 1'b1;
    iclkena = 1'b1;
    ival    = 1'b0;
    isop    = 1'b0;
    ieop    = 1'b0;
    istatem = '0;

    tab[0].min_mode = 0; tab[0].m = {64{8'd10}};  tab[0].m[37] = 8'd50;
    tab[0].st = 37; tab[0].met = 50;    tab[0].tie = 0;
    tab[1].min_mode = 0; tab[1].m = {64{8'hF0}};  tab[1].m[5] = 8'h02; tab[1].m[6] = 8'hFE;
    tab[1].st = 5;  tab[1].met = 8'h02; tab[1].tie = 0;
    tab[2].min_mode = 0; tab[2].m = {64{8'd7}};
    tab[2].st = 0;  tab[2].met = 7;     tab[2].tie = 1;
    tab[3].min_mode = 0; tab[3].m = {64{8'd0}};   tab[3].m[10] = 8'd99; tab[3].m[50] = 8'd99;
    tab[3].st = 10; tab[3].met = 99;    tab[3].tie = 1;
    tab[4].min_mode = 1; tab[4].m = {64{8'd1}};   tab[4].m[63] = 8'd0;
    tab[4].st = 63; tab[4].met = 0;     tab[4].tie = 0;
    tab[5].min_mode = 1; tab[5].m = {64{8'd7}};
    tab[5].st = 0;  tab[5].met = 7;     tab[5].tie = 1;
    tab[6].min_mode = 1; tab[6].m = {64{8'd100}}; tab[6].m[37] = 8'd5;
    tab[6].st = 37; tab[6].met = 5;     tab[6].tie = 0;

    repeat (3) nxt();
    ireset = 1'b0;
    nxt();

    // Directed vectors: latency on every instance, result on instances of the matching mode.
    for (int i = 0; i < 7; i++) begin
      single(tab[i].m);
      for (int d = 0; d < NDUT; d++) begin
        check($sformatf("tab%0d_lat_d%0d", i, d), lat_got[d], LAT[d]);
        if (MINM[d] == tab[i].min_mode) begin
          check($sformatf("tab%0d_state_d%0d", i, d), 32'(st_got[d]), tab[i].st);
          check($sformatf("tab%0d_metric_d%0d", i, d), 32'(met_got[d]), tab[i].met);
          check($sformatf("tab%0d_tie_d%0d", i, d), 32'(tie_got[d]), tab[i].tie);
        end
      end
    end

    // Markers without ival are dropped; sop and eop together travel on one oval.
    isop = 1'b1;
    ieop = 1'b1;
    nxt();
    isop = 1'b0;
    ieop = 1'b0;
    repeat (8) nxt();
    isop = 1'b1;
    ieop = 1'b1;
    single(rand_vec());
    isop = 1'b0;
    ieop = 1'b0;

    // Back-to-back stream, then the same stream under random clock-enable gaps.
    for (int i = 0; i < 100; i++) stream[i] = rand_vec();
    run_stream(1'b0);
    ref_seq = got_q;
    run_stream(1'b1);
    check("gated_seq_len", got_q.size(), ref_seq.size());
    for (int i = 0; i < 100; i++)
      if (i < got_q.size() && i < ref_seq.size())
        check($sformatf("gated_seq_%0d", i), got_q[i], ref_seq[i]);

    // Reset with two vectors in flight, then a fresh vector after release.
    ival    = 1'b1;
    istatem = rand_vec();
    nxt();
    istatem = rand_vec();
    nxt();
    ival   = 1'b0;
    ireset = 1'b1;
    nxt();
    ireset = 1'b0;
    begin
      int c0;
      c0 = oval_cnt[0];
      single(tab[0].m);
      check("post_rst_lat_d0", lat_got[0], LAT[0]);
      check("post_rst_lat_d2", lat_got[2], LAT[2]);
      check("post_rst_state_d0", 32'(st_got[0]), 37);
      check("post_rst_count_d0", oval_cnt[0] - c0, 1);
    end

    repeat (4) nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
